scmp_mem_arbiter: RTL and testbench

Single-port memory arbiter and CPU bus sequencer for the SC/MP board designs. It sits between the `scmp` core's bus strobes (ADS_n/RD_n/WR_n), a debug/loader port and one synchronous-read on-chip RAM. It turns CPU strobe edges into single-cycle RAM accesses and serves debug transactions in idle slots. It also latches the status flags the CPU drives on D_o[7:4] during ADS_n.

---
 rtl/scmp_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_scmp_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_mem_arbiter.sv
// SC/MP bus sequencer: turns CPU strobe edges into single-cycle RAM accesses,
// fills idle slots with debug/loader transactions and latches the CPU status flags.
module scmp_mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_ads_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic [11:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_d_o,
    output logic [DATA_W-1:0] cpu_d_i,
    output logic [3:0]        cpu_flags,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CPU_WR  = 3'd1;
    localparam logic [2:0] CPU_RD  = 3'd2;
    localparam logic [2:0] RD_CAP  = 3'd3;
    localparam logic [2:0] DBG     = 3'd4;
    localparam logic [2:0] DBG_ACK = 3'd5;

    // Strobe pipelines are packed {ads, rd, wr}
    logic [2:0]        s_strb_q, p_strb_q;
    logic              ads_fall, rd_fall, wr_fall;
    logic [2:0]        state_q, state_d;
    logic              rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    logic              take_wr, take_rd, take_dbg;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, ram_addr_q;
    logic [DATA_W-1:0] wr_data_q, ram_wdata_q, cpu_d_i_q, dbg_rdata_q;
    logic [3:0]        cpu_flags_q;
    logic              ram_en_q, ram_we_q, dbg_ack_q, dbg_rd_q;
    logic              unused_bits;

    assign ads_fall = p_strb_q[2] & ~s_strb_q[2];
    assign rd_fall  = p_strb_q[1] & ~s_strb_q[1];
    assign wr_fall  = p_strb_q[0] & ~s_strb_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_strb_q <= 3'b111;
            p_strb_q <= 3'b111;
        end else begin
            s_strb_q <= {cpu_ads_n, cpu_rd_n, cpu_wr_n};
            p_strb_q <= s_strb_q;
        end
    end

    // A CPU edge still in the detector blocks debug, so the CPU wins a tie
    always_comb begin
        state_d  = state_q;
        take_wr  = 1'b0;
        take_rd  = 1'b0;
        take_dbg = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    take_wr = 1'b1;
                    state_d = CPU_WR;
                end else if (rd_pend_q) begin
                    take_rd = 1'b1;
                    state_d = CPU_RD;
                end else if (dbg_req && !rd_fall && !wr_fall) begin
                    take_dbg = 1'b1;
                    state_d  = DBG;
                end
            end
            CPU_WR:  state_d = IDLE;
            CPU_RD:  state_d = RD_CAP;
            RD_CAP:  state_d = IDLE;
            DBG:     state_d = DBG_ACK;
            DBG_ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_pend_d = wr_fall | (wr_pend_q & ~take_wr);
        rd_pend_d = rd_fall | (rd_pend_q & ~take_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_pend_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_flags_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            if (rd_fall) rd_addr_q <= cpu_addr[ADDR_W-1:0];
            if (wr_fall) begin
                wr_addr_q <= cpu_addr[ADDR_W-1:0];
                wr_data_q <= cpu_d_o;
            end
            if (ads_fall) cpu_flags_q <= cpu_d_o[7:4];
        end
    end

    // RAM strobes are registered on the IDLE decision so they line up with the access state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            dbg_rd_q    <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
            cpu_d_i_q   <= '1;
        end else begin
            ram_en_q  <= take_wr | take_rd | take_dbg;
            ram_we_q  <= take_wr | (take_dbg & dbg_we);
            dbg_ack_q <= (state_q == DBG);
            if (take_wr) begin
                ram_addr_q  <= wr_addr_q;
                ram_wdata_q <= wr_data_q;
            end else if (take_rd) begin
                ram_addr_q <= rd_addr_q;
            end else if (take_dbg) begin
                ram_addr_q  <= dbg_addr;
                ram_wdata_q <= dbg_wdata;
                dbg_rd_q    <= ~dbg_we;
            end
            if (state_q == DBG_ACK && dbg_rd_q) dbg_rdata_q <= ram_rdata;
            if (s_strb_q[1]) cpu_d_i_q <= '1;
            else if (state_q == RD_CAP) cpu_d_i_q <= ram_rdata;
        end
    end

    // RAM data arrives during the ack cycle, so it is passed straight through there
    assign dbg_rdata = (dbg_ack_q && dbg_rd_q) ? ram_rdata : dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_d_i   = cpu_d_i_q;
    assign cpu_flags = cpu_flags_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

    assign unused_bits = ^{cpu_addr[11:ADDR_W], cpu_d_o[3:0]};

endmodule

// File: tb/tb_scmp_mem_arbiter.sv
// Randomized bench for scmp_mem_arbiter: a synchronous RAM model on the RAM port and a
// reference memory image that predicts every CPU and debug read.
module tb_scmp_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_ads_n, cpu_rd_n, cpu_wr_n;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_d_o, cpu_d_i;
    logic [3:0]  cpu_flags;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [6:0]  dbg_addr;
    logic [7:0]  dbg_wdata, dbg_rdata;
    logic        ram_en, ram_we;
    logic [6:0]  ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    logic [7:0]  mem    [128];
    logic [7:0]  refMem [128];
    logic        bdWe;
    logic [6:0]  bdAddr;
    logic [7:0]  bdData;

    logic [8:0]  accLog[$];
    int          weCount = 0, ackCount = 0;
    logic [6:0]  lastWeAddr;
    logic [7:0]  lastWeData;

    int          testsRun = 0, failCount = 0;

    logic [11:0] ca;
    logic [7:0]  dv, wd;
    bit          ackSeen, cpuSeen, okFlag, found;
    int          base, a0;

    always #5 clk = ~clk;

    scmp_mem_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_ads_n(cpu_ads_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_addr(cpu_addr), .cpu_d_o(cpu_d_o), .cpu_d_i(cpu_d_i), .cpu_flags(cpu_flags),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Synchronous-read RAM with a backdoor write port for preloading
    always @(posedge clk) begin
        if (bdWe) mem[bdAddr] <= bdData;
        else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    // Bus monitor: one log entry per RAM access, plus ack and write counters
    always @(negedge clk) begin
        if (ram_en) begin
            accLog.push_back({ram_we, ram_addr});
            if (ram_we) begin
                weCount++;
                lastWeAddr = ram_addr;
                lastWeData = ram_wdata;
            end
        end
        if (dbg_ack) ackCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpuRead(input logic [11:0] a, input int maxLat);
        logic [7:0] exp;
        bit got;
        int lat;
        exp = refMem[a[6:0]];
        got = 0;
        lat = 0;
        @(negedge clk);
        cpu_addr = a;
        cpu_rd_n = 1'b0;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clk);
            if (cpu_d_i !== 8'hFF) begin
                got = 1;
                lat = i;
            end
        end
        checkOutput("rdDone", 32'(got), 32'd1);
        checkOutput("rdData", 32'(cpu_d_i), 32'(exp));
        if (maxLat > 0) checkOutput("rdLatency", 32'(got && lat <= maxLat), 32'd1);
        waitCycles(2);
        checkOutput("rdHold", 32'(cpu_d_i), 32'(exp));
        cpu_rd_n = 1'b1;
        waitCycles(3);
        checkOutput("rdIdleFF", 32'(cpu_d_i), 32'hFF);
    endtask

    task automatic cpuWrite(input logic [11:0] a, input logic [7:0] d, input int hold);
        int w0;
        w0 = weCount;
        @(negedge clk);
        cpu_addr = a;
        cpu_d_o  = d;
        cpu_wr_n = 1'b0;
        waitCycles(hold);
        cpu_wr_n = 1'b1;
        waitCycles(6);
        checkOutput("wrCount", 32'(weCount - w0), 32'd1);
        checkOutput("wrAddr", 32'(lastWeAddr), 32'(a[6:0]));
        checkOutput("wrData", 32'(lastWeData), 32'(d));
        refMem[a[6:0]] = d;
    endtask

    task automatic pulseAds(input logic [7:0] d);
        @(negedge clk);
        cpu_d_o   = d;
        cpu_ads_n = 1'b0;
        waitCycles(3);
        cpu_d_o   = ~d;
        cpu_ads_n = 1'b1;
        waitCycles(3);
        checkOutput("flags", 32'(cpu_flags), 32'(d[7:4]));
    endtask

    task automatic dbgXfer(input bit we, input logic [6:0] a, input logic [7:0] wdat,
                           output logic [7:0] rdat, output bit acked);
        int c0;
        c0 = ackCount;
        acked = 0;
        rdat = 8'h00;
        @(negedge clk);
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = wdat;
        dbg_req   = 1'b1;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clk);
            if (dbg_ack) begin
                acked   = 1;
                rdat    = dbg_rdata;
                dbg_req = 1'b0;
            end
        end
        dbg_req = 1'b0;
        checkOutput("dbgAcked", 32'(acked), 32'd1);
        waitCycles(3);
        checkOutput("dbgAckOnce", 32'(ackCount - c0), 32'd1);
        if (we) refMem[a] = wdat;
        else    checkOutput("dbgRdata", 32'(rdat), 32'(refMem[a]));
    endtask

    task automatic applyStimulus(input int n);
        logic [7:0] r;
        bit ok;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 4))
                0: cpuRead(12'($urandom_range(0, 4095)), 0);
                1: cpuWrite(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 254)),
                            int'($urandom_range(2, 6)));
                2: dbgXfer(1'b0, 7'($urandom_range(0, 127)), 8'h00, r, ok);
                3: dbgXfer(1'b1, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 254)), r, ok);
                default: pulseAds(8'($urandom_range(0, 255)));
            endcase
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "CpuDi"},  32'(cpu_d_i),   32'hFF);
        checkOutput({tag, "Flags"},  32'(cpu_flags), 32'd0);
        checkOutput({tag, "Ack"},    32'(dbg_ack),   32'd0);
        checkOutput({tag, "Rdata"},  32'(dbg_rdata), 32'd0);
        checkOutput({tag, "RamEn"},  32'(ram_en),    32'd0);
        checkOutput({tag, "RamWe"},  32'(ram_we),    32'd0);
        checkOutput({tag, "RamAdr"}, 32'(ram_addr),  32'd0);
        checkOutput({tag, "RamWd"},  32'(ram_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cpu_ads_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        cpu_addr = 12'h000; cpu_d_o = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 7'd0; dbg_wdata = 8'h00;
        bdWe = 1'b0; bdAddr = 7'd0; bdData = 8'h00;

        // Preload the RAM while reset is held; data stays below 0xFF so reads are visible
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            bdWe   = 1'b1;
            bdAddr = 7'(i);
            bdData = (i == 5) ? 8'h3C : 8'($urandom_range(0, 254));
            refMem[i] = bdData;
        end
        @(negedge clk);
        bdWe = 1'b0;
        checkResetOutputs("rst");

        rst_n = 1'b1;
        waitCycles(10);
        checkOutput("noFalseEdge", 32'(accLog.size()), 32'd0);

        cpuRead(12'h005, 5);
        cpuWrite(12'h083, 8'hA5, 20);
        pulseAds(8'hB0);
        checkOutput("flagsHeld", 32'(cpu_flags), 32'hB);

        // CPU read edge and debug read of address 7 arrive together
        ca = 12'($urandom_range(0, 4095));
        base = accLog.size();
        a0 = ackCount;
        ackSeen = 0;
        cpuSeen = 0;
        dv = 8'h00;
        @(negedge clk);
        cpu_addr = ca;
        cpu_rd_n = 1'b0;
        @(negedge clk);
        dbg_we = 1'b0; dbg_addr = 7'd7; dbg_req = 1'b1;
        for (int i = 0; i < 20 && !(ackSeen && cpuSeen); i++) begin
            @(negedge clk);
            if (dbg_ack && !ackSeen) begin
                ackSeen = 1;
                dv = dbg_rdata;
                dbg_req = 1'b0;
            end
            if (cpu_d_i !== 8'hFF) cpuSeen = 1;
        end
        dbg_req = 1'b0;
        checkOutput("contCpuSeen", 32'(cpuSeen), 32'd1);
        checkOutput("contAckSeen", 32'(ackSeen), 32'd1);
        checkOutput("contCpuData", 32'(cpu_d_i), 32'(refMem[ca[6:0]]));
        checkOutput("contDbgData", 32'(dv), 32'(refMem[7]));
        checkOutput("contFirst", 32'((accLog.size() > base) ? accLog[base] : 9'h1FF),
                    32'({1'b0, ca[6:0]}));
        checkOutput("contSecond", 32'((accLog.size() > base + 1) ? accLog[base + 1] : 9'h1FF),
                    32'({1'b0, 7'd7}));
        cpu_rd_n = 1'b1;
        waitCycles(4);
        checkOutput("contAckOnce", 32'(ackCount - a0), 32'd1);

        dbgXfer(1'b1, 7'd9, 8'h5A, dv, okFlag);
        cpuRead(12'h009, 0);

        // Reset lands in the DBG write cycle: the write and its ack must be dropped
        a0 = ackCount;
        wd = refMem[20] ^ 8'h55;
        found = 0;
        @(negedge clk);
        dbg_we = 1'b1; dbg_addr = 7'd20; dbg_wdata = wd; dbg_req = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ram_en && ram_we) begin
                found = 1;
                rst_n = 1'b0;
            end
        end
        checkOutput("rstDbgWrSeen", 32'(found), 32'd1);
        #1;
        checkOutput("rstAsyncWe", 32'(ram_we), 32'd0);
        dbg_req = 1'b0;
        waitCycles(3);
        checkOutput("rstNoAck", 32'(ackCount - a0), 32'd0);
        checkResetOutputs("midRst");
        rst_n = 1'b1;
        waitCycles(3);
        cpuRead(12'h014, 0);

        applyStimulus(60);

        cpuWrite(12'hFFF, 8'h66, 3);
        cpuRead(12'h07F, 0);
        cpuWrite(12'h080, 8'h11, 3);
        cpuRead(12'h000, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
